// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Memory is addressed in 8-byte words; the low three address bits are dropped.
  localparam logic [63:0] MEM_ALIGN_MASK = ~64'h7;

  function automatic logic [31:0] select_word(input logic hi, input logic [63:0] word);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of data grants won while a fetch waits; flags when the fetch must win.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic force_if_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority so a fetch grant always restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and data accesses,
// one transaction at a time, with data priority bounded by a starvation counter.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_wen_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [63:0]       d_wdata_i,
  input  logic [7:0]        d_wmask_i,
  output logic              d_done_o,
  output logic [63:0]       d_rdata_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wen_o,
  output logic [63:0]       mem_wdata_o,
  output logic [7:0]        mem_wmask_o,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = MEM_ALIGN_MASK[ADDR_W-1:0];

  arb_state_e        state_q;
  logic              owner_q;
  logic              sel_hi_q;
  logic              mem_valid_q;
  logic              mem_wen_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [63:0]       mem_wdata_q;
  logic [7:0]        mem_wmask_q;
  logic              if_done_q;
  logic              d_done_q;
  logic [31:0]       if_rdata_q;
  logic [63:0]       d_rdata_q;

  logic in_idle;
  logic force_if;
  logic grant_d;
  logic grant_if;
  logic cnt_inc;
  logic cnt_clr;

  assign in_idle  = (state_q == ARB_IDLE);
  assign grant_d  = in_idle & d_req_i & ~(if_req_i & force_if);
  assign grant_if = in_idle & if_req_i & ~grant_d;
  assign cnt_inc  = grant_d & if_req_i;
  assign cnt_clr  = grant_if | (in_idle & ~if_req_i);

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_starve (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (cnt_inc),
    .clr_i     (cnt_clr),
    .force_if_o(force_if)
  );

  // Responses only count in WAIT, so stray or post-reset rvalids fall through.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      sel_hi_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (grant_d) begin
            owner_q     <= OWN_D;
            mem_addr_q  <= d_addr_i & ALIGN_MASK;
            mem_wen_q   <= d_wen_i;
            mem_wdata_q <= d_wdata_i;
            mem_wmask_q <= d_wen_i ? d_wmask_i : 8'h00;
            mem_valid_q <= 1'b1;
            state_q     <= ARB_REQ;
          end else if (grant_if) begin
            owner_q     <= OWN_IF;
            sel_hi_q    <= if_addr_i[2];
            mem_addr_q  <= if_addr_i & ALIGN_MASK;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_wmask_q <= 8'h00;
            mem_valid_q <= 1'b1;
            state_q     <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            state_q     <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_rvalid_i) begin
            if (owner_q == OWN_D) begin
              d_done_q  <= 1'b1;
              d_rdata_q <= mem_rdata_i;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= select_word(sel_hi_q, mem_rdata_i);
            end
            state_q <= ARB_RESP;
          end
        end
        ARB_RESP: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wen_o   = mem_wen_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wmask_o = mem_wmask_q;
  assign if_done_o   = if_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_done_o    = d_done_q;
  assign d_rdata_o   = d_rdata_q;
  assign stall_if_o  = if_req_i & ~if_done_q;
  assign stall_mem_o = d_req_i & ~d_done_q;

endmodule
